mask_splitter: RTL
==================

# mask_splitter

Sequential inverse of the datapath's bitwise OR: it takes one WIDTH-bit mask and emits its set bits as a stream of one-hot words, one per accepted beat. Bitwise OR of all one-hot words from one mask reproduces the mask. It sits between the processor's register/MMIO side and consumers that service one flag at a time, such as per-joint servo update requests on the arm controller. Valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32, mask width; must be ≥2.
- IDXW, $clog2(WIDTH), width of out_index (5 for default).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is released synchronously by the system.
- in_valid  input  1  in_mask is presented.
- in_ready  output  1  splitter can accept a mask.
- in_mask  input  WIDTH  mask to decompose.
- out_valid  output  1  out_onehot/out_index/out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_onehot  output  WIDTH  one-hot word for the current set bit; all-zero for an empty mask.
- out_index  output  IDXW  bit position of out_onehot; 0 for an empty mask.
- out_last  output  1  current beat is the final beat for this mask.
- busy  output  1  a mask is held (state EMIT).

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Internal register rem[WIDTH-1:0] holds the bits not yet emitted.
- IDLE → EMIT on in_valid&&in_ready.
  - rem ← in_mask.
  - Output registers are loaded with the first selected bit of in_mask.
- Selection is LSB-first by default: the lowest set bit of rem is selected.
  - out_onehot = rem & (~rem + 1), computed as a WIDTH-bit result with the carry discarded.
  - out_index = position of that bit.
  - out_last = 1 iff rem has exactly one set bit.
- On out_valid&&out_ready in EMIT:
  - If out_last=1: go to IDLE; rem ← 0.
  - Otherwise: rem ← rem & ~out_onehot, and the outputs are reloaded with the next selected bit.
- Empty mask (in_mask=0) is accepted and produces exactly one beat: out_onehot=0, out_index=0, out_last=1.
- Outputs are registered and remain stable while out_valid=1 and out_ready=0. The source must hold in_mask only during the handshake cycle; it is captured.
- in_valid while in EMIT is ignored (in_ready=0). No mask is lost or merged.
- Reset values:
  - state=IDLE, rem=0.
  - in_ready=1, out_valid=0, out_onehot=0, out_index=0, out_last=0, busy=0.
- Reset mid-operation: remaining beats are discarded with no further output. After release the block starts in IDLE.

## Timing
- Latency: mask accepted at edge N → first beat has out_valid=1 after edge N.
- Beats per mask = max(popcount(in_mask), 1). With out_ready held high, one beat is issued per cycle.
- After the last-beat handshake at edge M, in_ready=1 after edge M. The next mask can be accepted at edge M+1.
- Throughput: popcount+1 cycles per mask with no backpressure, e.g. 33 cycles for 0xFFFFFFFF.
- No combinational path from in_* to out_* or from out_ready to in_ready. All outputs come from flops.

## Configuration
- MASK_SPLITTER_MSB_FIRST_EN:
  - Defined: selection is highest set bit first. out_onehot = the MSB of rem, and out_index is its position. The order of beats is reversed relative to LSB-first; everything else is identical.
  - Undefined (default): LSB-first as described above.

## Test plan
- Reset then in_mask=0x0000_0000 → one beat: out_onehot=0, out_index=0, out_last=1. in_ready returns the cycle after that beat.
- in_mask=0x8000_0011, out_ready=1 → three beats, in order:
  - 0x1 / index 0 / last 0
  - 0x10 / index 4 / last 0
  - 0x8000_0000 / index 31 / last 1
  - With MASK_SPLITTER_MSB_FIRST_EN defined, the same three beats appear in reverse order, and last=1 on the 0x1 beat.
- in_mask=0xFFFF_FFFF with out_ready toggling randomly:
  - Outputs stay stable during stalls.
  - Exactly 32 beats, indices 0..31.
  - OR of all out_onehot = 0xFFFF_FFFF.
- in_valid held high across a whole decomposition with a changing in_mask → only masks present when in_ready=1 are accepted. No beat ever mixes bits from two masks.
- Assert reset_n=0 after the 2nd beat of 0x0000_F000 → out_valid=0 and in_ready=1 immediately. After release, no residual beats; the next mask 0x2 gives a single beat: index 1, last=1.
- Random masks (≥1000) → for each mask:
  - Beat count = max(popcount, 1).
  - OR of the beats equals the mask.
  - Each out_onehot has at most one bit set.

Source files
------------

// File: rtl/mask_splitter.sv
// mask_splitter: decomposes one WIDTH-bit mask into a stream of one-hot beats.
// Latency: first beat is valid the cycle after the mask is accepted; then one beat per cycle.
// Backpressure: in_ready is low for the whole decomposition; beats hold steady while out_ready is low.
// Optional feature: define MASK_SPLITTER_MSB_FIRST_EN to emit the highest set bit first.
module mask_splitter #(
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;

  // Candidate set for the next beat: a fresh mask in IDLE, or what is left
  // after removing the bit currently on the output in EMIT.
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sel_onehot;
  logic [IDXW-1:0]  sel_index;
  logic             sel_last;

  // Pick the source of the next selection.
  always_comb begin
    cand = rem & ~out_onehot;
    if (state == IDLE) begin
      cand = in_mask;
    end
  end

`ifdef MASK_SPLITTER_MSB_FIRST_EN
  // Highest set bit of the candidate; an empty candidate yields zero/zero.
  always_comb begin
    sel_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i]) begin
        sel_index = IDXW'(i);
      end
    end
    sel_onehot = '0;
    if (cand != '0) begin
      sel_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << sel_index;
    end
  end
`else
  // Lowest set bit of the candidate: two's-complement isolation, carry dropped.
  always_comb begin
    sel_onehot = cand & (~cand + {{(WIDTH-1){1'b0}}, 1'b1});
    sel_index  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_index = IDXW'(i);
      end
    end
  end
`endif

  // The selected beat is the last one when at most one bit is set; this also
  // covers the empty mask, which yields a single all-zero beat.
  always_comb begin
    sel_last = ((cand & (cand - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
  end

  // Control FSM with every output held in a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= EMIT;
            rem        <= in_mask;
            in_ready   <= 1'b0;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            out_onehot <= sel_onehot;
            out_index  <= sel_index;
            out_last   <= sel_last;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              // Final beat taken: clear the datapath and reopen the input.
              state      <= IDLE;
              rem        <= '0;
              in_ready   <= 1'b1;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              out_onehot <= '0;
              out_index  <= '0;
              out_last   <= 1'b0;
            end else begin
              rem        <= cand;
              out_onehot <= sel_onehot;
              out_index  <= sel_index;
              out_last   <= sel_last;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rem       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
